// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: owns PC and IR, fetches words from instruction
// memory over a req/ack handshake and reports sticky timeouts.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadIR,
  input  logic              incPC,
  input  logic              loadPC,
  input  logic              selA,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  output logic              busy,
  output logic              fault,
  output logic              cmd_drop,
  output logic [1:0]        dbg_state
);

  // Handshake: imem_req rises with imem_addr and both hold until a cycle with
  // imem_ack=1, which completes the read; imem_ack outside a fetch is ignored.

  localparam int                CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_ir;
  logic              r_valid;
  logic              r_req;
  logic              r_busy;
  logic              r_fault;
  logic              r_drop;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_jump;
  logic              w_cmd;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_jump = loadPC & selA;
  assign w_cmd  = loadIR | incPC | w_jump;

  // Jump target comes from the IR already held, never from the word in flight.
  assign w_pc_next = w_jump ? r_ir[ADDR_W-1:0] :
                     incPC  ? r_pc + ADDR_W'(1) : r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_ir    <= '0;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
      r_drop  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pc <= w_pc_next;
          if (loadIR) begin
            r_addr  <= r_pc;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_drop <= w_cmd;
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_MAX) begin
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
            r_state <= S_FAULT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FAULT: begin
          r_drop <= w_cmd;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign ir        = r_ir;
  assign opcode    = r_ir[DATA_W-1:DATA_W-4];
  assign pc        = r_pc;
  assign ir_valid  = r_valid;
  assign busy      = r_busy;
  assign fault     = r_fault;
  assign cmd_drop  = r_drop;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written timeout and
// reset sequences, then randomized traffic against a transaction-level model.
module tb_instr_fetch_unit;

  localparam int TIMEOUT = 4;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        loadIR = 1'b0, incPC = 1'b0, loadPC = 1'b0, selA = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        imem_req, ir_valid, busy, fault, cmd_drop;
  logic [7:0]  imem_addr, pc;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W(8), .DATA_W(16), .RESET_PC(8'h10), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .loadIR(loadIR), .incPC(incPC), .loadPC(loadPC),
    .selA(selA), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .opcode(opcode),
    .pc(pc), .ir_valid(ir_valid), .busy(busy), .fault(fault),
    .cmd_drop(cmd_drop), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver: inputs change on the falling edge, outputs read on the next falling edge
  task automatic tick(input logic [5:0] in, input logic [15:0] rd);
    {rst, loadIR, incPC, loadPC, selA, imem_ack} = in;
    imem_rdata = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  // directed vector table; flags = {ir_valid, imem_req, fault, cmd_drop}
  typedef struct {
    logic [5:0]  in;
    logic [15:0] rd;
    logic [7:0]  e_pc;
    logic [15:0] e_ir;
    logic [3:0]  e_flags;
    logic [7:0]  e_addr;
  } vec_t;

  function automatic vec_t v(input logic [5:0] in, input logic [15:0] rd,
                             input logic [7:0] p, input logic [15:0] i,
                             input logic [3:0] f, input logic [7:0] a);
    vec_t r;
    r.in = in; r.rd = rd; r.e_pc = p; r.e_ir = i; r.e_flags = f; r.e_addr = a;
    return r;
  endfunction

  vec_t vecs[20];

  // reference model (transaction level, cycle-stamped)
  logic [15:0] mem [256];
  logic [7:0]  m_pc, m_addr;
  logic [15:0] m_ir;
  logic        m_valid, m_busy, m_fault, m_drop;
  int          cyc, m_start;

  task automatic model_edge(input logic [5:0] in, input logic [15:0] rd);
    logic r, l, i, p, s, a, cmd;
    {r, l, i, p, s, a} = in;
    cyc++;
    if (r) begin
      m_pc = 8'h10; m_addr = 8'h10; m_ir = '0;
      m_valid = 1'b0; m_busy = 1'b0; m_fault = 1'b0; m_drop = 1'b0;
      return;
    end
    cmd = l | i | (p & s);
    m_drop = (m_busy | m_fault) & cmd;
    if (m_fault) begin
      // frozen until reset
    end else if (m_busy) begin
      if (a) begin
        m_ir = rd; m_valid = 1'b1; m_busy = 1'b0;
      end else if (cyc - m_start == TIMEOUT) begin
        m_fault = 1'b1; m_busy = 1'b0;
      end
    end else begin
      if (l) begin
        m_addr = m_pc; m_busy = 1'b1; m_valid = 1'b0; m_start = cyc;
      end
      if (p & s)  m_pc = m_ir[7:0];
      else if (i) m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic rand_step(input logic force_rst);
    logic [5:0] in;
    logic [15:0] rd;
    in[5] = force_rst || ($urandom_range(0, 39) == 0) || (m_fault && $urandom_range(0, 3) == 0);
    in[4] = ($urandom_range(0, 2) == 0);
    in[3] = ($urandom_range(0, 3) == 0);
    in[2] = ($urandom_range(0, 4) == 0);
    in[1] = ($urandom_range(0, 1) == 1);
    in[0] = ($urandom_range(0, 2) == 0);
    rd = mem[m_addr];
    {rst, loadIR, incPC, loadPC, selA, imem_ack} = in;
    imem_rdata = rd;
    @(posedge clk);
    model_edge(in, rd);
    @(negedge clk);
    chk("rnd_pc", pc, m_pc);
    chk("rnd_ir", ir, m_ir);
    chk("rnd_opcode", opcode, m_ir[15:12]);
    chk("rnd_ir_valid", ir_valid, m_valid);
    chk("rnd_req", imem_req, m_busy);
    chk("rnd_busy", busy, m_busy);
    chk("rnd_fault", fault, m_fault);
    chk("rnd_cmd_drop", cmd_drop, m_drop);
    if (m_busy) chk("rnd_addr", imem_addr, m_addr);
  endtask

  initial begin
    // in = {rst, loadIR, incPC, loadPC, selA, ack}
    vecs[0]  = v(6'b100000, 16'h0000, 8'h10, 16'h0000, 4'b0000, 8'h10);
    vecs[1]  = v(6'b100000, 16'h0000, 8'h10, 16'h0000, 4'b0000, 8'h10);
    vecs[2]  = v(6'b011000, 16'h0000, 8'h11, 16'h0000, 4'b0100, 8'h10);
    vecs[3]  = v(6'b000001, 16'h4A05, 8'h11, 16'h4A05, 4'b1000, 8'h10);
    vecs[4]  = v(6'b010000, 16'h0000, 8'h11, 16'h4A05, 4'b0100, 8'h11);
    vecs[5]  = v(6'b000001, 16'h7023, 8'h11, 16'h7023, 4'b1000, 8'h11);
    vecs[6]  = v(6'b001110, 16'h0000, 8'h23, 16'h7023, 4'b1000, 8'h11);
    vecs[7]  = v(6'b000100, 16'h0000, 8'h23, 16'h7023, 4'b1000, 8'h11);
    vecs[8]  = v(6'b001000, 16'h0000, 8'h24, 16'h7023, 4'b1000, 8'h11);
    vecs[9]  = v(6'b010000, 16'h0000, 8'h24, 16'h7023, 4'b0100, 8'h24);
    vecs[10] = v(6'b001000, 16'h0000, 8'h24, 16'h7023, 4'b0101, 8'h24);
    vecs[11] = v(6'b000000, 16'h0000, 8'h24, 16'h7023, 4'b0100, 8'h24);
    vecs[12] = v(6'b000001, 16'hB1C2, 8'h24, 16'hB1C2, 4'b1000, 8'h24);
    vecs[13] = v(6'b000001, 16'hFFFF, 8'h24, 16'hB1C2, 4'b1000, 8'h24);
    vecs[14] = v(6'b010110, 16'h0000, 8'hC2, 16'hB1C2, 4'b0100, 8'h24);
    vecs[15] = v(6'b000001, 16'h3355, 8'hC2, 16'h3355, 4'b1000, 8'h24);
    vecs[16] = v(6'b010000, 16'h0000, 8'hC2, 16'h3355, 4'b0100, 8'hC2);
    vecs[17] = v(6'b000001, 16'h90FF, 8'hC2, 16'h90FF, 4'b1000, 8'hC2);
    vecs[18] = v(6'b000110, 16'h0000, 8'hFF, 16'h90FF, 4'b1000, 8'hC2);
    vecs[19] = v(6'b001000, 16'h0000, 8'h00, 16'h90FF, 4'b1000, 8'hC2);

    for (int k = 0; k < 20; k++) begin
      tick(vecs[k].in, vecs[k].rd);
      chk($sformatf("vec%0d_pc", k), pc, vecs[k].e_pc);
      chk($sformatf("vec%0d_ir", k), ir, vecs[k].e_ir);
      chk($sformatf("vec%0d_opcode", k), opcode, vecs[k].e_ir[15:12]);
      chk($sformatf("vec%0d_ir_valid", k), ir_valid, vecs[k].e_flags[3]);
      chk($sformatf("vec%0d_req", k), imem_req, vecs[k].e_flags[2]);
      chk($sformatf("vec%0d_busy", k), busy, vecs[k].e_flags[2]);
      chk($sformatf("vec%0d_fault", k), fault, vecs[k].e_flags[1]);
      chk($sformatf("vec%0d_cmd_drop", k), cmd_drop, vecs[k].e_flags[0]);
      if (vecs[k].e_flags[2] || vecs[k].in[5])
        chk($sformatf("vec%0d_addr", k), imem_addr, vecs[k].e_addr);
    end

    // timeout: no ack, fault exactly TIMEOUT edges after the loadIR edge
    tick(6'b010000, 16'h0);
    chk("to_busy", busy, 1'b1);
    chk("to_addr", imem_addr, 8'h00);
    for (int k = 1; k < TIMEOUT; k++) begin
      tick(6'b000000, 16'h0);
      chk($sformatf("to_nofault_%0d", k), fault, 1'b0);
      chk($sformatf("to_req_%0d", k), imem_req, 1'b1);
    end
    tick(6'b000000, 16'h0);
    chk("to_fault", fault, 1'b1);
    chk("to_req_low", imem_req, 1'b0);
    chk("to_busy_low", busy, 1'b0);
    tick(6'b010001, 16'h1234);
    chk("to_late_ack_ir", ir, 16'h90FF);
    chk("to_ir_valid", ir_valid, 1'b0);
    chk("to_drop_lir", cmd_drop, 1'b1);
    chk("to_req_still_low", imem_req, 1'b0);
    tick(6'b000000, 16'h0);
    chk("to_drop_pulse", cmd_drop, 1'b0);
    chk("to_fault_sticky", fault, 1'b1);
    tick(6'b001000, 16'h0);
    chk("to_pc_frozen", pc, 8'h00);
    chk("to_drop_inc", cmd_drop, 1'b1);
    tick(6'b100000, 16'h0);
    chk("to_rst_fault", fault, 1'b0);
    chk("to_rst_pc", pc, 8'h10);

    // ack in the expiry cycle wins over the timeout
    tick(6'b010000, 16'h0);
    for (int k = 1; k < TIMEOUT; k++) tick(6'b000000, 16'h0);
    tick(6'b000001, 16'h5A5A);
    chk("exp_ack_fault", fault, 1'b0);
    chk("exp_ack_ir", ir, 16'h5A5A);
    chk("exp_ack_valid", ir_valid, 1'b1);
    chk("exp_ack_busy", busy, 1'b0);

    // reset mid-fetch, late ack ignored
    tick(6'b010000, 16'h0);
    chk("rmf_busy", busy, 1'b1);
    tick(6'b100000, 16'h0);
    chk("rmf_req", imem_req, 1'b0);
    chk("rmf_addr", imem_addr, 8'h10);
    tick(6'b000001, 16'hABCD);
    chk("rmf_req_after", imem_req, 1'b0);
    chk("rmf_ir", ir, 16'h0000);
    chk("rmf_valid", ir_valid, 1'b0);
    chk("rmf_busy_after", busy, 1'b0);

    // randomized traffic against the model
    foreach (mem[a]) mem[a] = 16'($urandom);
    cyc = 0; m_start = 0;
    m_pc = 8'h10; m_addr = 8'h10; m_ir = '0;
    m_valid = 1'b0; m_busy = 1'b0; m_fault = 1'b0; m_drop = 1'b0;
    rand_step(1'b1);
    for (int k = 0; k < 400; k++) rand_step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch responder that executes the PC/IR commands issued by the CPU controller FSM. It owns the program counter (PC) and the instruction register (IR). It fetches instruction words from instruction memory over a req/ack handshake and returns `opcode` to the controller. It sits between the controller and instruction memory, replacing the bare PC/IR registers.

## Interface
- `ADDR_W`, default 8: PC and instruction-memory address width.
- `DATA_W`, default 16: instruction width. Opcode is `ir[DATA_W-1:DATA_W-4]`. Must be ≥ ADDR_W+4.
- `RESET_PC`, default 0: PC value after reset.
- `TIMEOUT`, default 16: maximum wait in cycles for `imem_ack` before fault. Must be ≥ 2.
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `loadIR`, input, 1: fetch request; load IR from mem[PC].
- `incPC`, input, 1: PC ← PC+1.
- `loadPC`, input, 1: PC load strobe; effective only with `selA`.
- `selA`, input, 1: jump select; with `loadPC`, PC ← `ir[ADDR_W-1:0]`.
- `imem_req`, output, 1: read request to instruction memory.
- `imem_addr`, output, ADDR_W: read address; stable while `imem_req`=1.
- `imem_ack`, input, 1: memory data valid on `imem_rdata` this cycle.
- `imem_rdata`, input, DATA_W: instruction word.
- `ir`, output, DATA_W: instruction register.
- `opcode`, output, 4: `ir[DATA_W-1:DATA_W-4]`, combinational from IR.
- `pc`, output, ADDR_W: program counter.
- `ir_valid`, output, 1: IR holds a completed fetch.
- `busy`, output, 1: fetch in progress (state FETCH).
- `fault`, output, 1: sticky fetch timeout.
- `cmd_drop`, output, 1: one-cycle pulse when a command arrives outside IDLE.

## Operation
- States: IDLE, FETCH, FAULT.
- Reset (any state, including mid-fetch), applied next edge:
  - pc=RESET_PC, ir=0, ir_valid=0, imem_req=0, imem_addr=RESET_PC, busy=0, fault=0, cmd_drop=0, timeout counter=0, state IDLE.
  - A late `imem_ack` after reset is ignored.
- IDLE behaviour:
  - `loadIR`=1: latch imem_addr←pc, imem_req←1, ir_valid←0, counter←0, go FETCH.
  - PC update priority: (`loadPC`&`selA`) jump > `incPC` > hold. `loadPC` without `selA` is ignored.
  - PC updates are evaluated in the same cycle as `loadIR`. The fetch uses the pre-update PC.
  - Jump target is the current IR contents, not the word being fetched.
- FETCH behaviour:
  - `imem_req`=1 and `imem_addr` held until ack.
  - On `imem_ack`=1: ir←imem_rdata, ir_valid←1, imem_req←0, go IDLE.
  - Without ack: counter increments. If counter = TIMEOUT-1 with no ack: imem_req←0, fault←1, go FAULT.
  - Ack in the expiry cycle wins; no fault is raised.
- FAULT: terminal until `rst`. imem_req=0; ir and ir_valid frozen; pc frozen.
- Commands (`loadIR`, `incPC`, `loadPC`&`selA`) in FETCH or FAULT are ignored, pc unchanged, and `cmd_drop` pulses for 1 cycle the next cycle.
- `imem_ack` in IDLE or FAULT is ignored.
- PC arithmetic is modulo 2^ADDR_W: (2^ADDR_W−1)+1 wraps to 0, no flag.

## Timing
- Command sampled at edge N (IDLE) → `imem_req`/`imem_addr`/`busy` valid after edge N, and pc updated after edge N.
- Ack sampled at edge M → `ir`/`ir_valid`/`opcode` valid after M; `imem_req` and `busy` low after M.
- Zero-wait memory (ack in first request cycle): loadIR at N → IR valid after N+1. Back-to-back loadIR is accepted at N+2 at the earliest.
- Timeout: ack never arrives → `fault` high after edge N+TIMEOUT.
- `ir_valid` clears at the edge that starts a fetch and stays high between fetches.
- All outputs are registered except `opcode`.

## Test plan
- **Reset:** hold `rst` 2 cycles with RESET_PC=0x10 → pc=0x10, ir=0, ir_valid=0, imem_req=0, fault=0.
- **Zero-wait fetch + increment:** in IDLE, loadIR=1 and incPC=1 at pc=0x10, memory acks 1 cycle later with 0x4A05 → imem_addr=0x10, pc=0x11, then ir=0x4A05, opcode=4'h4, ir_valid=1, busy=0.
- **Jump priority:** ir=0x7023, loadPC=1, selA=1, incPC=1 → pc=0x23. Then loadPC=1, selA=0 alone → pc unchanged.
- **Wait states + dropped command:** ack delayed 3 cycles; incPC pulsed during FETCH → imem_addr stable, imem_req high 3 cycles, cmd_drop pulses once, pc unchanged, IR loads on ack.
- **Timeout:** TIMEOUT=4, no ack → fault=1 exactly 4 cycles after the loadIR edge. A later ack is ignored, loadIR is dropped, and only rst clears fault. Separately, ack on cycle 4 → no fault, IR loaded.
- **Wrap and reset mid-fetch:** pc=0xFF, incPC → pc=0x00. Assert rst during FETCH and ack 1 cycle later → imem_req=0, ir=0, ir_valid=0.
